// File: rtl/carrier_update_sched.sv
`default_nettype none
// ============================================================================
// carrier_update_sched: shadowed carrier-bank config, applied together at a master-carrier boundary
// Optional CARRSYNC_TIMEOUT_EN forces the apply if no boundary arrives. Rev 1.0
// ============================================================================
module carrier_update_sched #(
  parameter int NCH = 8,
  parameter int CW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [CW-1:0]     cfg_period,
  input  logic [CW-1:0]     cfg_init,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_onoff,
  input  logic              commit,
  input  logic [NCH*CW-1:0] carrier_in,
  output logic [NCH*CW-1:0] period_o,
  output logic [NCH*CW-1:0] init_o,
  output logic [NCH*2-1:0]  mode_o,
  output logic [NCH-1:0]    onoff_o,
  output logic [NCH-1:0]    pending_o,
  output logic              busy,
  output logic              update_done,
  output logic              timeout_o
);

  // Count mode encoding: 0 NO_COUNT, 1 COUNT_UP, 2 COUNT_DOWN, 3 COUNT_UPDOWN; onoff 0 = CARR_OFF
  localparam logic [1:0] NO_COUNT   = 2'd0;
  localparam logic [1:0] COUNT_DOWN = 2'd2;
  localparam logic       CARR_OFF   = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   sh_period_q [NCH];
  logic [CW-1:0]   sh_period_d [NCH];
  logic [CW-1:0]   sh_init_q   [NCH];
  logic [CW-1:0]   sh_init_d   [NCH];
  logic [1:0]      sh_mode_q   [NCH];
  logic [1:0]      sh_mode_d   [NCH];
  logic            sh_onoff_q  [NCH];
  logic            sh_onoff_d  [NCH];
  logic [CW-1:0]   period_q    [NCH];
  logic [CW-1:0]   period_d    [NCH];
  logic [CW-1:0]   init_q      [NCH];
  logic [CW-1:0]   init_d      [NCH];
  logic [1:0]      mode_q      [NCH];
  logic [1:0]      mode_d      [NCH];
  logic            onoff_q     [NCH];
  logic            onoff_d     [NCH];
  logic [NCH-1:0]  pending_q, pending_d;
  logic [CW-1:0]   prev_q, prev_d;
  logic            cfg_ready_q, cfg_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            w_wr;
  logic            w_master_stopped;
  logic [CW-1:0]   w_bound;
  logic            w_boundary;
  logic            w_unused_carrier;

`ifdef CARRSYNC_TIMEOUT_EN
  localparam logic [CW+1:0] TO_ONE = (CW+2)'(1);
  localparam logic [CW+1:0] TO_TWO = (CW+2)'(2);
  logic [CW+1:0]   to_cnt_q, to_cnt_d;
  logic            forced_q, forced_d;
  logic            timeout_q, timeout_d;
  logic [CW+1:0]   w_to_limit;

  assign w_to_limit = {1'b0, period_q[0], 1'b0} + TO_TWO;
  assign timeout_o  = timeout_q;
`else
  assign timeout_o  = 1'b0;
`endif

  assign w_wr             = cfg_valid && cfg_ready_q;
  assign w_master_stopped = (mode_q[0] == NO_COUNT) || (onoff_q[0] == CARR_OFF) || (period_q[0] == '0);
  assign w_bound          = (mode_q[0] == COUNT_DOWN) ? period_q[0] : '0;
  // Boundary needs a fresh arrival at the bound, so a carrier parked there does not retrigger
  assign w_boundary       = (carrier_in[CW-1:0] == w_bound) && (carrier_in[CW-1:0] != prev_q);
  assign w_unused_carrier = ^carrier_in[NCH*CW-1:CW];

  always_comb begin
    state_d     = state_q;
    sh_period_d = sh_period_q;
    sh_init_d   = sh_init_q;
    sh_mode_d   = sh_mode_q;
    sh_onoff_d  = sh_onoff_q;
    period_d    = period_q;
    init_d      = init_q;
    mode_d      = mode_q;
    onoff_d     = onoff_q;
    pending_d   = pending_q;
    prev_d      = carrier_in[CW-1:0];
    done_d      = (state_q == S_APPLY);
`ifdef CARRSYNC_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    forced_d    = forced_q;
    timeout_d   = (state_q == S_APPLY) && forced_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (w_wr) begin
          sh_period_d[cfg_ch] = cfg_period;
          sh_init_d[cfg_ch]   = cfg_init;
          sh_mode_d[cfg_ch]   = cfg_mode;
          sh_onoff_d[cfg_ch]  = cfg_onoff;
          pending_d[cfg_ch]   = 1'b1;
        end
        // A write in the commit cycle counts as pending for that commit
        if (commit && ((pending_q != '0) || w_wr)) begin
          state_d = w_master_stopped ? S_APPLY : S_ARMED;
`ifdef CARRSYNC_TIMEOUT_EN
          to_cnt_d = '0;
          forced_d = 1'b0;
`endif
        end
      end

      S_ARMED: begin
`ifdef CARRSYNC_TIMEOUT_EN
        to_cnt_d = to_cnt_q + TO_ONE;
`endif
        if (w_boundary) begin
          state_d = S_APPLY;
        end
`ifdef CARRSYNC_TIMEOUT_EN
        else if (to_cnt_d == w_to_limit) begin
          state_d  = S_APPLY;
          forced_d = 1'b1;
        end
`endif
      end

      S_APPLY: begin
        for (int i = 0; i < NCH; i++) begin
          if (pending_q[i]) begin
            period_d[i] = sh_period_q[i];
            init_d[i]   = sh_init_q[i];
            mode_d[i]   = sh_mode_q[i];
            onoff_d[i]  = sh_onoff_q[i];
          end
        end
        pending_d = '0;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    cfg_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NCH; i++) begin
        sh_period_q[i] <= '0;
        sh_init_q[i]   <= '0;
        sh_mode_q[i]   <= NO_COUNT;
        sh_onoff_q[i]  <= CARR_OFF;
        period_q[i]    <= '0;
        init_q[i]      <= '0;
        mode_q[i]      <= NO_COUNT;
        onoff_q[i]     <= CARR_OFF;
      end
      pending_q   <= '0;
      prev_q      <= '0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef CARRSYNC_TIMEOUT_EN
      to_cnt_q    <= '0;
      forced_q    <= 1'b0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sh_period_q <= sh_period_d;
      sh_init_q   <= sh_init_d;
      sh_mode_q   <= sh_mode_d;
      sh_onoff_q  <= sh_onoff_d;
      period_q    <= period_d;
      init_q      <= init_d;
      mode_q      <= mode_d;
      onoff_q     <= onoff_d;
      pending_q   <= pending_d;
      prev_q      <= prev_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef CARRSYNC_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      forced_q    <= forced_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign period_o[g*CW +: CW] = period_q[g];
    assign init_o[g*CW +: CW]   = init_q[g];
    assign mode_o[g*2 +: 2]     = mode_q[g];
    assign onoff_o[g]           = onoff_q[g];
  end

  assign cfg_ready   = cfg_ready_q;
  assign pending_o   = pending_q;
  assign busy        = busy_q;
  assign update_done = done_q;

endmodule
`default_nettype wire
